// File: rtl/warmboot_pkg.sv
// rtl/warmboot_pkg.sv - shared types and the slot address helper for warmboot_ctrl
package warmboot_pkg;

    typedef enum logic [2:0] {
        ST_PRE_RESET,
        ST_REQ,
        ST_WAIT,
        ST_POST_RESET,
        ST_RUN,
        ST_FAIL
    } warmboot_state_t;

    localparam int ADDR_CALC_BITS = 64;

    // Computed wide; callers truncate to their loader address width.
    function automatic logic [ADDR_CALC_BITS-1:0] slot_addr(
        input logic [ADDR_CALC_BITS-1:0] slot,
        input logic [ADDR_CALC_BITS-1:0] base,
        input logic [ADDR_CALC_BITS-1:0] stride
    );
        return base + slot * stride;
    endfunction

endpackage

// File: rtl/warmboot_hold_cnt.sv
// rtl/warmboot_hold_cnt.sv - loadable down-counter for reset hold and load watchdog
module warmboot_hold_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             last
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/warmboot_ctrl.sv
// rtl/warmboot_ctrl.sv - cold/warm boot sequencer; WARMBOOT_WATCHDOG_EN adds a load timeout
module warmboot_ctrl
    import warmboot_pkg::*;
#(
    parameter int SLOT_BITS      = 4,
    parameter int NUM_SLOTS      = 16,
    parameter int DEFAULT_SLOT   = 0,
    parameter int ADDR_BITS      = 24,
    parameter int BASE_ADDR      = 0,
    parameter int SLOT_STRIDE    = 'h10000,
    parameter int RESET_HOLD     = 16,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [SLOT_BITS-1:0] slot_i,
    input  logic                 boot_i,
    output logic                 fabric_reset_o,
    output logic                 configured_o,
    output logic                 load_valid_o,
    input  logic                 load_ready_i,
    output logic [ADDR_BITS-1:0] load_addr_o,
    input  logic                 load_done_i,
    input  logic                 load_err_i,
    output logic [SLOT_BITS-1:0] active_slot_o,
    output logic                 fallback_o,
    output logic                 fail_o
);

    localparam int CNT_MAX  = (TIMEOUT_CYCLES > RESET_HOLD) ? TIMEOUT_CYCLES : RESET_HOLD;
    localparam int CNT_BITS = $clog2(CNT_MAX + 1);
    localparam logic [CNT_BITS-1:0]  HOLD_LOAD = CNT_BITS'(RESET_HOLD);
    localparam logic [SLOT_BITS-1:0] DEF_SLOT  = SLOT_BITS'(DEFAULT_SLOT);

    warmboot_state_t      state;
    logic [SLOT_BITS-1:0] target;
    logic                 boot_q;

    logic                 cnt_load;
    logic                 cnt_dec;
    logic [CNT_BITS-1:0]  cnt_val;
    logic                 cnt_zero;
    logic                 cnt_last;

    logic                 boot_rise;
    logic                 target_valid;
    logic [SLOT_BITS-1:0] target_fix;
    logic                 load_ok;
    logic                 load_bad;

    assign boot_rise    = boot_i && !boot_q;
    assign target_valid = (32'(target) < NUM_SLOTS);
    assign target_fix   = target_valid ? target : DEF_SLOT;
    assign load_ok      = load_done_i && !load_err_i;

`ifdef WARMBOOT_WATCHDOG_EN
    // A silent loader is treated as a failed load once the watchdog expires.
    assign load_bad = (load_done_i && load_err_i) || (!load_done_i && cnt_last);
`else
    assign load_bad = load_done_i && load_err_i;
`endif

    // Hold counts down RESET_HOLD..1; a zero count in PRE_RESET only follows rst_i.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = HOLD_LOAD;
        case (state)
            ST_PRE_RESET: begin
                if (cnt_zero) cnt_load = 1'b1;
                else          cnt_dec  = 1'b1;
            end
            ST_REQ: begin
`ifdef WARMBOOT_WATCHDOG_EN
                if (load_ready_i) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_BITS'(TIMEOUT_CYCLES);
                end
`endif
            end
            ST_WAIT: begin
                if (load_ok || (load_bad && target != DEF_SLOT)) begin
                    cnt_load = 1'b1;
                end else begin
`ifdef WARMBOOT_WATCHDOG_EN
                    cnt_dec = 1'b1;
`endif
                end
            end
            ST_POST_RESET: cnt_dec = 1'b1;
            ST_RUN:        if (boot_rise) cnt_load = 1'b1;
            default: ;
        endcase
    end

    warmboot_hold_cnt #(
        .WIDTH(CNT_BITS)
    ) u_hold_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .zero    (cnt_zero),
        .last    (cnt_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_PRE_RESET;
            target         <= DEF_SLOT;
            boot_q         <= 1'b0;
            fabric_reset_o <= 1'b1;
            configured_o   <= 1'b0;
            load_valid_o   <= 1'b0;
            load_addr_o    <= '0;
            active_slot_o  <= DEF_SLOT;
            fallback_o     <= 1'b0;
            fail_o         <= 1'b0;
        end else begin
            boot_q <= boot_i;
            case (state)
                ST_PRE_RESET: begin
                    fabric_reset_o <= 1'b1;
                    configured_o   <= 1'b0;
                    if (!target_valid) begin
                        target     <= DEF_SLOT;
                        fallback_o <= 1'b1;
                    end
                    if (cnt_last) begin
                        state         <= ST_REQ;
                        load_valid_o  <= 1'b1;
                        load_addr_o   <= ADDR_BITS'(slot_addr(ADDR_CALC_BITS'(target_fix),
                                                              ADDR_CALC_BITS'(BASE_ADDR),
                                                              ADDR_CALC_BITS'(SLOT_STRIDE)));
                        active_slot_o <= target_fix;
                    end
                end
                ST_REQ: begin
                    if (load_ready_i) begin
                        state        <= ST_WAIT;
                        load_valid_o <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (load_ok) begin
                        state        <= ST_POST_RESET;
                        configured_o <= 1'b1;
                    end else if (load_bad) begin
                        if (target != DEF_SLOT) begin
                            state      <= ST_PRE_RESET;
                            target     <= DEF_SLOT;
                            fallback_o <= 1'b1;
                        end else begin
                            state  <= ST_FAIL;
                            fail_o <= 1'b1;
                        end
                    end
                end
                ST_POST_RESET: begin
                    if (cnt_last) begin
                        state          <= ST_RUN;
                        fabric_reset_o <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (boot_rise) begin
                        state          <= ST_PRE_RESET;
                        target         <= slot_i;
                        fallback_o     <= 1'b0;
                        fabric_reset_o <= 1'b1;
                        configured_o   <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    fail_o         <= 1'b1;
                    fabric_reset_o <= 1'b1;
                    configured_o   <= 1'b0;
                    load_valid_o   <= 1'b0;
                end
                default: state <= ST_PRE_RESET;
            endcase
        end
    end

endmodule
